// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares the program/data RAM between the CPU path and an external loader
module ram_bus_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_SAT  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {CPU = 2'b00, LOAD = 2'b01, RELEASE = 2'b10} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;

    assign cpu_stall = (state != CPU);
    assign ld_gnt    = (state == LOAD);
    assign owner     = state;
    assign cpu_rdata = ram_rdata;
    assign ld_rdata  = ram_rdata;

    // RAM port mux; RELEASE parks on the CPU address with no write, and reset blocks writes
    always_comb begin
        ram_addr  = (state == LOAD) ? ld_addr : cpu_addr;
        ram_wdata = (state == LOAD) ? ld_wdata : cpu_wdata;
        ram_we    = reset && ((state == CPU)  ? (cpu_req && cpu_we) :
                              (state == LOAD) ? (ld_req && ld_we) : 1'b0);
    end

    // ownership transitions with starvation and burst limits
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        burst_nxt  = burst_cnt;
        case (state)
            CPU: begin
                if (ld_req && (!cpu_req || starve_cnt == STARVE_MAX)) begin
                    state_nxt  = LOAD;
                    starve_nxt = '0;
                    burst_nxt  = '0;
                end else begin
                    starve_nxt = ld_req ? starve_cnt + 1'b1 : '0;
                end
            end
            LOAD: begin
                if (!ld_req) begin
                    state_nxt = RELEASE;
                end else begin
                    burst_nxt = (burst_cnt == BURST_SAT) ? burst_cnt : burst_cnt + 1'b1;
                    state_nxt = (cpu_req && burst_cnt >= BURST_LAST) ? RELEASE : LOAD;
                end
            end
            RELEASE: begin
                state_nxt  = CPU;
                starve_nxt = '0;
            end
            default: state_nxt = CPU;
        endcase
    end

    // state, counters and loader read-valid registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= CPU;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            ld_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
            ld_valid   <= (state == LOAD) && ld_req && !ld_we;
        end
    end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single 16x8 program/data RAM between the CPU control path and an external program loader (DMA-style port).
- The CPU path has zero-latency ownership by default. The loader gets the bus through a request/grant handshake with starvation and burst limits.
- cpu_stall feeds the control unit's halt input, freezing the step counter while the loader owns the RAM.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
STARVE_LIMIT, 4, consecutive contested cycles the CPU may win before the loader is forced in (>=1)
MAX_BURST, 16, loader accesses per grant before forced release while the CPU is waiting (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
cpu_req  in  1  CPU RAM access this cycle
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address (MAR)
cpu_wdata  in  DATA_W  CPU write data (bus)
cpu_rdata  out  DATA_W  read data, valid the cycle after a CPU read
cpu_stall  out  1  CPU must freeze (to control-unit halt)
ld_req  in  1  loader access request; held high for the whole session
ld_we  in  1  loader write enable
ld_addr  in  ADDR_W  loader address
ld_wdata  in  DATA_W  loader write data
ld_gnt  out  1  loader owns the RAM
ld_valid  out  1  ld_rdata valid (cycle after a granted loader read)
ld_rdata  out  DATA_W  loader read data
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM synchronous read data, 1-cycle latency
owner  out  2  FSM state: 00 CPU, 01 LOAD, 10 RELEASE

Behaviour:
- Reset (reset==0 at posedge):
  - state=CPU; starve_cnt=0; burst_cnt=0; ld_valid=0.
  - ld_gnt=0; cpu_stall=0.
  - ram_we is forced 0 in any cycle where reset is low.
- Mux:
  - In CPU state: ram_addr/ram_wdata = cpu_*, ram_we = cpu_req & cpu_we.
  - In LOAD state: ram_addr/ram_wdata = ld_*, ram_we = ld_req & ld_we.
  - In RELEASE state: ram_we=0, ram_addr = cpu_addr.
  - cpu_rdata and ld_rdata are both wired to ram_rdata.
- Combinational outputs: cpu_stall = (state!=CPU); ld_gnt = (state==LOAD).
- CPU state:
  - cpu_req is always serviced the same cycle.
  - Transition to LOAD when ld_req & (!cpu_req | starve_cnt==STARVE_LIMIT-1).
  - Otherwise: starve_cnt increments when ld_req & cpu_req, and clears when !ld_req.
  - On entry to LOAD: starve_cnt=0, burst_cnt=0.
- LOAD state:
  - Each cycle with ld_req=1 is a granted access; burst_cnt increments, saturating at MAX_BURST.
  - ld_req=0 causes no RAM access that cycle; next state is RELEASE.
  - Forced release: a granted access with burst_cnt==MAX_BURST-1 while cpu_req=1 -> RELEASE.
  - If cpu_req=0, the loader keeps the bus and burst_cnt stays saturated.
  - A cpu_req arriving after saturation -> RELEASE at the next granted access or on ld_req drop.
  - CPU requests during LOAD are not serviced. The CPU holds them because it is stalled.
- RELEASE state: one turnaround cycle with no RAM access. cpu_stall stays 1 and ld_gnt=0. Next state is CPU with starve_cnt=0.
- ld_valid is registered: 1 in the cycle after a LOAD-state cycle with ld_req & !ld_we, else 0. It can therefore be 1 during RELEASE.
- A loader still holding ld_req after a forced release re-arbitrates from CPU state under the normal rules. The earliest re-grant is the cycle after returning to CPU.
- Reset asserted mid-LOAD or mid-RELEASE: the next state is CPU with no write issued in the reset cycle. The loader sees ld_gnt drop and must restart its session.
- Counter widths hold values up to STARVE_LIMIT-1 and MAX_BURST. There is no wrap-around.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ld_req=1, cpu_req=1, we=1 -> ram_we=0, ld_gnt=0, cpu_stall=0, owner=00; ld_valid=0 on release.
- CPU passthrough: CPU writes 0x5A to addr 3, then reads addr 3 -> ram_we pulse with addr 3; cpu_rdata=0x5A one cycle after the read; cpu_stall stays 0.
- Idle grant: ld_req=1, cpu_req=0 at cycle t -> ld_gnt=1 and cpu_stall=1 at t+1. Loader writes 0x11..0x14 to addrs 0..3, drops ld_req -> owner=10 for one cycle, then 00; RAM holds 0x11..0x14.
- Starvation: cpu_req=1 continuously, ld_req rises at t -> CPU serviced t..t+3; ld_gnt=1 at t+4 (STARVE_LIMIT=4).
- Burst cap: loader holds ld_req with reads while cpu_req=1 -> exactly 16 granted accesses; ld_valid pulses 16 times; RELEASE; CPU resumes serviced 2 cycles after the last loader access.
- Reset mid-LOAD: reset=0 during a loader write to addr 7 -> no write to addr 7; owner=00, ld_gnt=0 next cycle.
